game_stage_ctrl: RTL and testbench
==================================

Name: game_stage_ctrl

Overview:
- Game-flow controller for the fighter display path.
- Owns the stage state (start / battle / win / lose) and the player and NPC health counters.
- Drives the one-hot stage levels (start_l, battle_l, win_l, lose_l) consumed by the colour mapper and word generators.
- Drives thermometer health masks consumed by the health-bar segment generators, which produce the per-segment pixel flags.
- Sits between the hit-detection/keyboard logic and the pixel colouring stage; updates are frame-synchronous.

Parameters:
- MAX_HEALTH, 5, starting health and width of the health masks (1..8).
- HIT_COOLDOWN, 30, frames of invulnerability after a target takes a hit.
- END_HOLD_FRAMES, 120, frames the WIN/LOSE screen ignores start_key.

Ports:
- Clk  input  1  system clock.
- Reset_n  input  1  asynchronous active-low reset.
- frame_clk  input  1  vertical-sync-rate frame strobe, asynchronous to Clk.
- start_key  input  1  level from keycode decode; start/restart request.
- npc_hit  input  1  level: player projectile overlaps NPC this cycle.
- player_hit  input  1  level: NPC projectile overlaps player this cycle.
- start_l  output  1  stage START.
- battle_l  output  1  stage BATTLE.
- win_l  output  1  stage WIN.
- lose_l  output  1  stage LOSE.
- player_health  output  MAX_HEALTH  thermometer; bit i = (player hp > i).
- npc_health  output  MAX_HEALTH  thermometer; bit i = (npc hp > i).

Behaviour:
- Reset (async assert, sync release):
  - state = START, so start_l=1 and the other stage outputs are 0.
  - Both hp = MAX_HEALTH, so both health masks are all ones.
  - Cooldowns, hold counter, sticky hit flags and edge detectors are all 0.
- Stage outputs are registered and one-hot in every cycle.
- frame_clk handling:
  - Two-flop synchroniser, then rising-edge detect, giving frame_tick: a one-Clk pulse.
  - Latency from a frame_clk rise to frame_tick is 3 Clk cycles.
- start_key handling:
  - Registered, then rising-edge detect, giving key_edge.
  - A held key produces exactly one event.
- Hit capture:
  - npc_hit and player_hit each set a sticky flag.
  - The flags are consumed and cleared on frame_tick.
  - An assertion in the same cycle as frame_tick counts for the following frame.
- START:
  - hp held at MAX_HEALTH.
  - key_edge → BATTLE; hp reloaded; cooldowns cleared; sticky flags cleared.
- BATTLE, on frame_tick, for each target independently:
  - If cooldown > 0: decrement cooldown and discard the sticky flag.
  - Else if the sticky flag is set: hp decrements, saturating at 0, and cooldown loads HIT_COOLDOWN.
  - Transitions are evaluated on the updated hp, in the cycle after the tick.
  - npc hp = 0 → WIN.
  - player hp = 0 → LOSE.
  - Both reach 0 on the same tick → LOSE (player loses ties).
  - On entry to WIN/LOSE, the hold counter loads END_HOLD_FRAMES.
- WIN / LOSE:
  - hp frozen; the masks show final values.
  - Hold counter decrements on frame_tick down to 0.
  - key_edge is ignored while hold > 0.
  - key_edge with hold = 0 → START; hp reloaded to MAX_HEALTH.
- Hit inputs are ignored outside BATTLE, and the sticky flags are held cleared.
- Reset asserted mid-battle returns to START immediately, with all counters reloaded.
- Counter widths: cooldown counter sized by $clog2(HIT_COOLDOWN+1); hold counter sized by $clog2(END_HOLD_FRAMES+1); hp counter sized by $clog2(MAX_HEALTH+1).

Optional Feature:
- Macro: PLAYER_INVULN_EN.
- Defined:
  - player hp never decrements, so LOSE is unreachable.
  - player_hit is still captured but discarded.
  - Cooldown for the player stays 0.
- Undefined: behaviour exactly as specified above.

Test Plan:
- Reset check: assert Reset_n=0 asynchronously mid-cycle → outputs go immediately to start_l=1, player_health=5'b11111, npc_health=5'b11111.
- Start and hit: pulse start_key → battle_l=1 one cycle later. Assert npc_hit 1 cycle, then one frame_clk rise → npc_health=5'b01111 at 3 Clk + 1 after the rise.
- Cooldown: hold npc_hit high for 40 frames with HIT_COOLDOWN=30 → exactly 2 decrements, on frame 1 and frame 32, giving npc_health=5'b00111.
- Win path and hold: 5 spaced npc hits → win_l=1 and npc_health=0. start_key during the 120 hold frames → no change. start_key after hold → start_l=1 and both masks 5'b11111.
- Simultaneous final hit: both hp=1 and both hits land on the same frame → lose_l=1, both masks 0. With PLAYER_INVULN_EN defined, the same stimulus → win_l=1 and player_health unchanged.
- Key handling: held start_key over 10 frames in START → exactly one transition. Hits asserted in START → no hp change after entering BATTLE.

Source files
------------

// File: rtl/game_stage_ctrl.sv
// game_stage_ctrl: stage FSM (start / battle / win / lose) and the player/NPC
// health counters for the fighter display path. All game updates are paced by
// frame_tick, a one-Clk pulse derived from the asynchronous frame_clk strobe.
// Optional build macro: PLAYER_INVULN_EN (player never loses health).
module game_stage_ctrl #(
    parameter int MAX_HEALTH      = 5,
    parameter int HIT_COOLDOWN    = 30,
    parameter int END_HOLD_FRAMES = 120
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  frame_clk,
    input  logic                  start_key,
    input  logic                  npc_hit,
    input  logic                  player_hit,
    output logic                  start_l,
    output logic                  battle_l,
    output logic                  win_l,
    output logic                  lose_l,
    output logic [MAX_HEALTH-1:0] player_health,
    output logic [MAX_HEALTH-1:0] npc_health
);
    localparam int HP_W   = $clog2(MAX_HEALTH + 1);
    localparam int CD_W   = $clog2(HIT_COOLDOWN + 1);
    localparam int HOLD_W = $clog2(END_HOLD_FRAMES + 1);

    localparam logic [HP_W-1:0]   HP_FULL   = HP_W'(MAX_HEALTH);
    localparam logic [CD_W-1:0]   CD_LOAD   = CD_W'(HIT_COOLDOWN);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(END_HOLD_FRAMES);

    // One-hot encoding so the stage outputs come straight off the state flops.
    typedef enum logic [3:0] {
        ST_START  = 4'b1000,
        ST_BATTLE = 4'b0100,
        ST_WIN    = 4'b0010,
        ST_LOSE   = 4'b0001
    } stage_t;

    stage_t              state, state_n;
    logic [HP_W-1:0]     player_hp, player_hp_n, npc_hp, npc_hp_n;
    logic [CD_W-1:0]     player_cd, player_cd_n, npc_cd, npc_cd_n;
    logic [HOLD_W-1:0]   hold, hold_n;
    logic                player_flag, player_flag_n, npc_flag, npc_flag_n;
    logic [1:0]          rst_sync;
    logic                rst_int_n;
    logic [2:0]          frame_sync;
    logic                frame_tick;
    logic                key_q, key_q2;
    logic                key_edge;

    // Reset synchroniser: assertion is immediate, release lines up with Clk.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    // frame_clk crosses domains through two flops; the third flop feeds the edge detect.
    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            frame_sync <= '0;
            frame_tick <= 1'b0;
            key_q      <= 1'b0;
            key_q2     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the pre-edge values.
            frame_sync <= {frame_sync[1:0], frame_clk};
            frame_tick <= frame_sync[1] & ~frame_sync[2];
            key_q      <= start_key;
            key_q2     <= key_q;
        end
    end

    // A held key gives one event only.
    assign key_edge = key_q & ~key_q2;

    // State, health, cooldown, hold and sticky-hit registers.
    always_ff @(posedge Clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state       <= ST_START;
            player_hp   <= HP_FULL;
            npc_hp      <= HP_FULL;
            player_cd   <= '0;
            npc_cd      <= '0;
            hold        <= '0;
            player_flag <= 1'b0;
            npc_flag    <= 1'b0;
        end else begin
            state       <= state_n;
            player_hp   <= player_hp_n;
            npc_hp      <= npc_hp_n;
            player_cd   <= player_cd_n;
            npc_cd      <= npc_cd_n;
            hold        <= hold_n;
            player_flag <= player_flag_n;
            npc_flag    <= npc_flag_n;
        end
    end

    // Next-state and counter update logic for the stage FSM.
    always_comb begin
        // NOTE: every signal gets a hold-value default first, so no path infers a latch.
        state_n       = state;
        player_hp_n   = player_hp;
        npc_hp_n      = npc_hp;
        player_cd_n   = player_cd;
        npc_cd_n      = npc_cd;
        hold_n        = hold;
        player_flag_n = player_flag;
        npc_flag_n    = npc_flag;

        case (state)
            ST_START: begin
                player_hp_n   = HP_FULL;
                npc_hp_n      = HP_FULL;
                player_cd_n   = '0;
                npc_cd_n      = '0;
                player_flag_n = 1'b0;
                npc_flag_n    = 1'b0;
                if (key_edge) state_n = ST_BATTLE;
            end

            ST_BATTLE: begin
                // Leave on the hp that the previous tick produced; player loses ties.
                if (player_hp == '0) begin
                    state_n = ST_LOSE;
                    hold_n  = HOLD_LOAD;
                end else if (npc_hp == '0) begin
                    state_n = ST_WIN;
                    hold_n  = HOLD_LOAD;
                end else if (frame_tick) begin
                    // Flags are consumed now; a hit landing on the tick belongs to the next frame.
                    npc_flag_n    = npc_hit;
                    player_flag_n = player_hit;

                    if (npc_cd != '0) begin
                        npc_cd_n = npc_cd - CD_W'(1);
                    end else if (npc_flag) begin
                        if (npc_hp != '0) npc_hp_n = npc_hp - HP_W'(1);
                        npc_cd_n = CD_LOAD;
                    end

`ifdef PLAYER_INVULN_EN
                    // Player hits are captured but never cost health.
                    player_cd_n = '0;
`else
                    if (player_cd != '0) begin
                        player_cd_n = player_cd - CD_W'(1);
                    end else if (player_flag) begin
                        if (player_hp != '0) player_hp_n = player_hp - HP_W'(1);
                        player_cd_n = CD_LOAD;
                    end
`endif
                end else begin
                    npc_flag_n    = npc_flag | npc_hit;
                    player_flag_n = player_flag | player_hit;
                end
            end

            ST_WIN, ST_LOSE: begin
                player_flag_n = 1'b0;
                npc_flag_n    = 1'b0;
                if (frame_tick && hold != '0) hold_n = hold - HOLD_W'(1);
                if (key_edge && hold == '0) begin
                    state_n     = ST_START;
                    player_hp_n = HP_FULL;
                    npc_hp_n    = HP_FULL;
                    player_cd_n = '0;
                    npc_cd_n    = '0;
                end
            end

            default: state_n = ST_START;
        endcase
    end

    assign {start_l, battle_l, win_l, lose_l} = state;

    // Thermometer masks for the health-bar segment generators.
    always_comb begin
        for (int i = 0; i < MAX_HEALTH; i++) begin
            player_health[i] = (int'(player_hp) > i);
            npc_health[i]    = (int'(npc_hp) > i);
        end
    end

endmodule

// File: tb/tb_game_stage_ctrl.sv
// Self-checking bench for game_stage_ctrl with default parameters.
// Expected output vectors are queued when stimulus is driven and popped when
// the DUT output is due.
module tb_game_stage_ctrl;
    localparam int MH = 5;
    localparam int OW = 4 + 2 * MH;

    localparam logic [3:0]    S_START  = 4'b1000;
    localparam logic [3:0]    S_BATTLE = 4'b0100;
    localparam logic [3:0]    S_WIN    = 4'b0010;
    localparam logic [3:0]    S_LOSE   = 4'b0001;
    localparam logic [MH-1:0] FULL     = 5'b11111;
    localparam logic [MH-1:0] EMPTY    = 5'b00000;

    logic          Clk        = 1'b0;
    logic          Reset_n    = 1'b0;
    logic          frame_clk  = 1'b0;
    logic          start_key  = 1'b0;
    logic          npc_hit    = 1'b0;
    logic          player_hit = 1'b0;
    logic          start_l, battle_l, win_l, lose_l;
    logic [MH-1:0] player_health, npc_health;

    typedef struct {
        string         name;
        logic [OW-1:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    game_stage_ctrl #(
        .MAX_HEALTH     (MH),
        .HIT_COOLDOWN   (30),
        .END_HOLD_FRAMES(120)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_clk    (frame_clk),
        .start_key    (start_key),
        .npc_hit      (npc_hit),
        .player_hit   (player_hit),
        .start_l      (start_l),
        .battle_l     (battle_l),
        .win_l        (win_l),
        .lose_l       (lose_l),
        .player_health(player_health),
        .npc_health   (npc_health)
    );

    always #5 Clk = ~Clk;

    function automatic logic [OW-1:0] obs();
        return {start_l, battle_l, win_l, lose_l, player_health, npc_health};
    endfunction

    // One frame: frame_clk high 4 cycles, low 4 cycles (hp settles within the high phase + 1).
    task automatic frame();
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic press_key();
        start_key = 1'b1;
        repeat (2) @(negedge Clk);
        start_key = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    // One-cycle hit pulse followed by a frame that consumes it.
    task automatic hit(input logic n, input logic p);
        npc_hit    = n;
        player_hit = p;
        @(negedge Clk);
        npc_hit    = 1'b0;
        player_hit = 1'b0;
        frame();
    endtask

    // Enough frames for a loaded cooldown to run out completely.
    task automatic drain();
        repeat (31) frame();
    endtask

    task automatic test_reset();
        exp_t e;
        sb.push_back('{"reset_state", {S_START, FULL, FULL}});
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (4) @(negedge Clk);
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    endtask

    task automatic test_hits_in_start();
        exp_t e;
        sb.push_back('{"start_hits_ignored", {S_START, FULL, FULL}});
        npc_hit    = 1'b1;
        player_hit = 1'b1;
        frame();
        frame();
        npc_hit    = 1'b0;
        player_hit = 1'b0;
        @(negedge Clk);
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    endtask

    task automatic test_start_key();
        exp_t e;
        sb.push_back('{"key_plus1", {S_START, FULL, FULL}});
        sb.push_back('{"key_plus2", {S_BATTLE, FULL, FULL}});
        start_key = 1'b1;
        @(negedge Clk);
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        @(negedge Clk);
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        // Key held for 10 frames; earlier START hits must not have left anything behind.
        sb.push_back('{"held_key_battle_full", {S_BATTLE, FULL, FULL}});
        repeat (10) frame();
        start_key = 1'b0;
        @(negedge Clk);
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    endtask

    task automatic test_hit_latency();
        exp_t e;
        sb.push_back('{"tick_plus3", {S_BATTLE, FULL, FULL}});
        sb.push_back('{"tick_plus4", {S_BATTLE, FULL, 5'b01111}});
        npc_hit = 1'b1;
        @(negedge Clk);
        npc_hit   = 1'b0;
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        @(negedge Clk);
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic test_async_reset();
        exp_t e;
        sb.push_back('{"async_reset", {S_START, FULL, FULL}});
        @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (4) @(negedge Clk);
    endtask

    task automatic test_cooldown();
        exp_t e;
        press_key();
        sb.push_back('{"cd_frame1", {S_BATTLE, FULL, 5'b01111}});
        npc_hit = 1'b1;
        frame();
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        sb.push_back('{"cd_frame31", {S_BATTLE, FULL, 5'b01111}});
        repeat (30) frame();
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        sb.push_back('{"cd_frame32", {S_BATTLE, FULL, 5'b00111}});
        frame();
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        sb.push_back('{"cd_frame40", {S_BATTLE, FULL, 5'b00111}});
        repeat (8) frame();
        npc_hit = 1'b0;
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    endtask

    task automatic test_win_hold();
        exp_t e;
        drain();
        hit(1'b1, 1'b0);
        drain();
        sb.push_back('{"npc_hp1", {S_BATTLE, FULL, 5'b00001}});
        hit(1'b1, 1'b0);
        drain();
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        sb.push_back('{"win_entry", {S_WIN, FULL, EMPTY}});
        hit(1'b1, 1'b0);
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        sb.push_back('{"key_hold_start", {S_WIN, FULL, EMPTY}});
        press_key();
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        // After 119 frames one hold frame remains, so the key is still ignored.
        sb.push_back('{"key_hold_1", {S_WIN, FULL, EMPTY}});
        repeat (119) frame();
        press_key();
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        frame();
        sb.push_back('{"restart", {S_START, FULL, FULL}});
        start_key = 1'b1;
        repeat (2) @(negedge Clk);
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        // The same held key must not also launch a new battle.
        sb.push_back('{"held_key_no_retrigger", {S_START, FULL, FULL}});
        repeat (10) frame();
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        start_key = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_simultaneous();
        exp_t e;
        int   waited;
        logic [MH-1:0] ph_one;
        logic [OW-1:0] final_v;
`ifdef PLAYER_INVULN_EN
        ph_one  = FULL;
        final_v = {S_WIN, FULL, EMPTY};
`else
        ph_one  = 5'b00001;
        final_v = {S_LOSE, EMPTY, EMPTY};
`endif
        press_key();
        sb.push_back('{"both_hp1", {S_BATTLE, ph_one, 5'b00001}});
        repeat (4) begin
            hit(1'b1, 1'b1);
            drain();
        end
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        sb.push_back('{"simultaneous_final", final_v});
        npc_hit    = 1'b1;
        player_hit = 1'b1;
        @(negedge Clk);
        npc_hit    = 1'b0;
        player_hit = 1'b0;
        frame_clk  = 1'b1;
        waited = 0;
        while (!(win_l || lose_l) && waited < 16) begin
            @(negedge Clk);
            waited++;
        end
        n_cmp++;
        if (!(win_l || lose_l)) begin
            n_bad++;
            $display("FAIL end_stage_timeout: got no end stage after %0d cycles, expected win_l or lose_l", waited);
        end
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e.v) begin n_bad++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    initial begin
        test_reset();
        test_hits_in_start();
        test_start_key();
        test_hit_latency();
        test_async_reset();
        test_cooldown();
        test_win_hold();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
